boron_iter_engine: RTL and testbench

Parametrised iterative BORON encryption engine, the successor to the fixed 64/128-bit free-running top.
- Generalised in key width, round count and rounds-per-cycle unrolling.
- Adds a valid/ready input/output handshake, an explicit FSM, on-chip key schedule and output hold under backpressure.
- Sits between the host block buffer and the ciphertext sink; one block in flight at a time.

---
 rtl/boron_pkg.sv | 54 +++++
 rtl/boron_if.sv | 26 ++
 rtl/boron_round.sv | 29 ++
 rtl/boron_iter_engine.sv | 105 ++++++++++
 tb/tb_boron_iter_engine.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/boron_pkg.sv
// Shared BORON constants, FSM state type and the round building blocks
// used by the round datapath.
package boron_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_ROT = 13;
  localparam int RIDX_HI = 63;
  localparam int RIDX_LO = 59;

  localparam logic [3:0] SBOX [16] = '{
    4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
    4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic [3:0] boron_sbox(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    for (int i = 0; i < BLOCK_W / 4; i++) y[4*i +: 4] = boron_sbox(x[4*i +: 4]);
    return y;
  endfunction

  // Byte swap inside each 16-bit word.
  function automatic logic [BLOCK_W-1:0] block_shuffle(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    for (int j = 0; j < 4; j++) y[16*j +: 16] = {x[16*j +: 8], x[16*j+8 +: 8]};
    return y;
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] w, input int n);
    return (w << n) | (w >> (16 - n));
  endfunction

  function automatic logic [BLOCK_W-1:0] round_p(input logic [BLOCK_W-1:0] x);
    return {rotl16(x[63:48], 9), rotl16(x[47:32], 7),
            rotl16(x[31:16], 4), rotl16(x[15:0], 1)};
  endfunction

  // Word mixing; each step uses the word updated by the previous one.
  function automatic logic [BLOCK_W-1:0] boron_xor(input logic [BLOCK_W-1:0] x);
    logic [15:0] w0, w1, w2, w3;
    {w3, w2, w1, w0} = x;
    w1 = w1 ^ w0;
    w3 = w3 ^ w2;
    w0 = w0 ^ w3;
    w2 = w2 ^ w1;
    return {w3, w2, w1, w0};
  endfunction

endpackage

// File: rtl/boron_if.sv
// Block-in / ciphertext-out handshake bundle between host buffer and engine.
interface boron_if
  import boron_pkg::*;
#(
  parameter int KEY_WIDTH = 128
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [BLOCK_W-1:0]   plain_txt;
  logic [KEY_WIDTH-1:0] key_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [BLOCK_W-1:0]   cipher_txt;

  modport master (
    output in_valid, plain_txt, key_in, out_ready,
    input  in_ready, out_valid, cipher_txt
  );

  modport slave (
    input  in_valid, plain_txt, key_in, out_ready,
    output in_ready, out_valid, cipher_txt
  );

endinterface

// File: rtl/boron_round.sv
// One combinational BORON round: data path plus the matching key-schedule step.
module boron_round
  import boron_pkg::*;
#(
  parameter int KEY_WIDTH = 128,
  parameter int CNT_W     = 5
) (
  input  logic [BLOCK_W-1:0]   state,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [CNT_W-1:0]     round_idx,
  output logic [BLOCK_W-1:0]   next_state,
  output logic [KEY_WIDTH-1:0] next_key
);

  logic [KEY_WIDTH-1:0] key_rot;
  logic [4:0]           ridx;

  // NOTE: blocking assignments with every output given a value first keep this block latch-free.
  always_comb begin
    next_state = boron_xor(round_p(block_shuffle(sbox_layer(state ^ key[BLOCK_W-1:0]))));
    ridx       = 5'(round_idx + CNT_W'(1));
    key_rot    = {key[KEY_WIDTH-KEY_ROT-1:0], key[KEY_WIDTH-1:KEY_WIDTH-KEY_ROT]};
    next_key   = key_rot;
    next_key[3:0] = boron_sbox(key_rot[3:0]);
    if (KEY_WIDTH == 128) next_key[7:4] = boron_sbox(key_rot[7:4]);
    next_key[RIDX_HI:RIDX_LO] = key_rot[RIDX_HI:RIDX_LO] ^ ridx;
  end

endmodule

// File: rtl/boron_iter_engine.sv
// Iterative BORON encryption engine: UNROLL rounds per clock, one block in
// flight, ciphertext held under backpressure.
module boron_iter_engine
  import boron_pkg::*;
#(
  parameter int KEY_WIDTH  = 128,
  parameter int NUM_ROUNDS = 25,
  parameter int UNROLL     = 1,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  boron_if.slave           bus,
  output logic             busy,
  output logic [CNT_W-1:0] round_cnt
);

  if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_key_width
    $error("boron_iter_engine: KEY_WIDTH must be 80 or 128");
  end
  if (UNROLL < 1 || (NUM_ROUNDS % UNROLL) != 0) begin : g_bad_unroll
    $error("boron_iter_engine: UNROLL must divide NUM_ROUNDS");
  end
  if ((1 << CNT_W) <= NUM_ROUNDS) begin : g_bad_cnt_w
    $error("boron_iter_engine: CNT_W too narrow for NUM_ROUNDS");
  end

  state_e               state;
  logic [BLOCK_W-1:0]   state_reg;
  logic [KEY_WIDTH-1:0] key_reg;
  logic [BLOCK_W-1:0]   cipher_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [BLOCK_W-1:0]   blk_chain [UNROLL+1];
  logic [KEY_WIDTH-1:0] key_chain [UNROLL+1];

  assign blk_chain[0] = state_reg;
  assign key_chain[0] = key_reg;

  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    boron_round #(
      .KEY_WIDTH (KEY_WIDTH),
      .CNT_W     (CNT_W)
    ) u_round (
      .state      (blk_chain[i]),
      .key        (key_chain[i]),
      .round_idx  (round_cnt + CNT_W'(i)),
      .next_state (blk_chain[i+1]),
      .next_key   (key_chain[i+1])
    );
  end

  // NOTE: non-blocking for all state; data registers are cleared by reset too so an aborted block leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      round_cnt   <= '0;
      cipher_q    <= '0;
      state_reg   <= '0;
      key_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg  <= bus.plain_txt;
            key_reg    <= bus.key_in;
            round_cnt  <= '0;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          state_reg <= blk_chain[UNROLL];
          key_reg   <= key_chain[UNROLL];
          round_cnt <= round_cnt + CNT_W'(UNROLL);
          if (int'(round_cnt) + UNROLL == NUM_ROUNDS) begin
            // Final whitening with the key produced by the last round.
            cipher_q    <= blk_chain[UNROLL] ^ key_chain[UNROLL][BLOCK_W-1:0];
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.cipher_txt = cipher_q;

endmodule

// File: tb/tb_boron_iter_engine.sv
// Self-checking bench: four engine configurations share one stimulus stream
// and are compared against an arithmetic reference model.
module tb_boron_iter_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic [63:0]  plain;
  logic [127:0] key;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  boron_if #(.KEY_WIDTH(128)) b1  ();
  boron_if #(.KEY_WIDTH(128)) b5  ();
  boron_if #(.KEY_WIDTH(128)) b25 ();
  boron_if #(.KEY_WIDTH(80))  b80 ();

  assign b1.in_valid  = in_valid;  assign b1.plain_txt  = plain; assign b1.key_in  = key;        assign b1.out_ready  = out_ready;
  assign b5.in_valid  = in_valid;  assign b5.plain_txt  = plain; assign b5.key_in  = key;        assign b5.out_ready  = out_ready;
  assign b25.in_valid = in_valid;  assign b25.plain_txt = plain; assign b25.key_in = key;        assign b25.out_ready = out_ready;
  assign b80.in_valid = in_valid;  assign b80.plain_txt = plain; assign b80.key_in = key[79:0];  assign b80.out_ready = out_ready;

  logic       busy1, busy5, busy25, busy80;
  logic [4:0] rc1, rc5, rc25, rc80;

  boron_iter_engine #(.KEY_WIDTH(128), .NUM_ROUNDS(25), .UNROLL(1), .CNT_W(5))
    dut (.clk(clk), .reset(reset), .bus(b1), .busy(busy1), .round_cnt(rc1));
  boron_iter_engine #(.KEY_WIDTH(128), .NUM_ROUNDS(25), .UNROLL(5), .CNT_W(5))
    dut_u5 (.clk(clk), .reset(reset), .bus(b5), .busy(busy5), .round_cnt(rc5));
  boron_iter_engine #(.KEY_WIDTH(128), .NUM_ROUNDS(25), .UNROLL(25), .CNT_W(5))
    dut_u25 (.clk(clk), .reset(reset), .bus(b25), .busy(busy25), .round_cnt(rc25));
  boron_iter_engine #(.KEY_WIDTH(80), .NUM_ROUNDS(25), .UNROLL(1), .CNT_W(5))
    dut_k80 (.clk(clk), .reset(reset), .bus(b80), .busy(busy80), .round_cnt(rc80));

  logic        ov [4];
  logic [63:0] ct [4];
  assign ov[0] = b1.out_valid;  assign ct[0] = b1.cipher_txt;
  assign ov[1] = b5.out_valid;  assign ct[1] = b5.cipher_txt;
  assign ov[2] = b25.out_valid; assign ct[2] = b25.cipher_txt;
  assign ov[3] = b80.out_valid; assign ct[3] = b80.cipher_txt;

  localparam int LAT [4] = '{26, 6, 2, 26};
  int sb [16] = '{14, 4, 11, 1, 7, 9, 12, 10, 13, 2, 0, 15, 8, 5, 3, 6};
  int rot [4] = '{1, 4, 7, 9};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: 25 rounds computed on 16-bit words held as integers.
  function automatic logic [63:0] ref_cipher(input logic [63:0] pt, input logic [127:0] k_in, input int kw);
    logic [127:0] k = k_in;
    logic [127:0] nk;
    logic [63:0]  s = pt;
    logic [63:0]  x;
    int w [4];
    for (int r = 0; r < 25; r++) begin
      x = s ^ k[63:0];
      for (int j = 0; j < 4; j++) begin
        w[j] = 0;
        for (int n = 3; n >= 0; n--) w[j] = w[j] * 16 + sb[x[16*j + 4*n +: 4]];
        w[j] = (w[j] % 256) * 256 + w[j] / 256;
        w[j] = ((w[j] << rot[j]) | (w[j] >> (16 - rot[j]))) & 'hFFFF;
      end
      w[1] = w[1] ^ w[0];
      w[3] = w[3] ^ w[2];
      w[0] = w[0] ^ w[3];
      w[2] = w[2] ^ w[1];
      for (int j = 0; j < 4; j++) s[16*j +: 16] = 16'(w[j]);
      nk = '0;
      for (int i = 0; i < kw; i++) nk[(i + 13) % kw] = k[i];
      nk[3:0] = 4'(sb[nk[3:0]]);
      if (kw == 128) nk[7:4] = 4'(sb[nk[7:4]]);
      nk[63:59] = nk[63:59] ^ 5'(r + 1);
      k = nk;
    end
    return s ^ k[63:0];
  endfunction

  task automatic reset_all();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One block through all four engines with out_ready high; checks data, latency and in_ready recovery.
  task automatic run_block(input string tag, input logic [63:0] pt, input logic [127:0] k,
                           input logic [63:0] exp128, input logic [63:0] exp80);
    int t0;
    int lat [4];
    logic [63:0] got [4];
    logic [63:0] exp [4];
    exp = '{exp128, exp128, exp128, exp80};
    for (int i = 0; i < 4; i++) begin lat[i] = -1; got[i] = '0; end
    @(negedge clk);
    check($sformatf("%s/in_ready_idle", tag), b1.in_ready, 1);
    plain = pt; key = k; in_valid = 1'b1; t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      for (int i = 0; i < 4; i++)
        if (lat[i] < 0 && ov[i]) begin lat[i] = cyc - t0; got[i] = ct[i]; end
      if (lat[0] == c) check($sformatf("%s/in_ready_done", tag), b1.in_ready, 0);
      if (lat[0] >= 0 && c == lat[0] + 1) begin
        check($sformatf("%s/in_ready_back", tag), b1.in_ready, 1);
        check($sformatf("%s/out_valid_drop", tag), b1.out_valid, 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s/lat%0d", tag, i), lat[i], LAT[i]);
      check($sformatf("%s/ct%0d", tag, i), got[i], exp[i]);
    end
  endtask

  typedef struct {
    logic [63:0]  pt;
    logic [127:0] key;
    logic [63:0]  exp128;
    logic [63:0]  exp80;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [63:0] hold;
    logic [63:0] exp_q [$];
    logic [63:0] pts [4];
    int c, hs, got, last;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; plain = '0; key = '0;

    vecs[0] = '{64'h0, 128'h0, 64'h0, 64'h0};
    vecs[1] = '{64'h0123456789ABCDEF, {128{1'b1}}, 64'h0, 64'h0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, {128{1'b1}}, 64'h0, 64'h0};
    vecs[3] = '{64'h8000_0000_0000_0001, 128'h1, 64'h0, 64'h0};
    for (int i = 0; i < 4; i++) begin
      vecs[i].exp128 = ref_cipher(vecs[i].pt, vecs[i].key, 128);
      vecs[i].exp80  = ref_cipher(vecs[i].pt, {48'h0, vecs[i].key[79:0]}, 80);
    end

    repeat (2) @(negedge clk);
    check("rst/in_ready", b1.in_ready, 1);
    check("rst/out_valid", b1.out_valid, 0);
    check("rst/busy", busy1, 0);
    check("rst/round_cnt", rc1, 0);
    check("rst/cipher", b1.cipher_txt, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_block($sformatf("vec%0d", i), vecs[i].pt, vecs[i].key, vecs[i].exp128, vecs[i].exp80);

    for (int i = 0; i < 6; i++) begin
      logic [63:0]  rp;
      logic [127:0] rk;
      rp = {$urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rnd%0d", i), rp, rk, ref_cipher(rp, rk, 128), ref_cipher(rp, {48'h0, rk[79:0]}, 80));
    end

    // Backpressure: ten stalled cycles with a competing in_valid.
    out_ready = 1'b0;
    plain = vecs[1].pt; key = vecs[1].key; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (!b1.out_valid && c < 40) begin @(negedge clk); c++; end
    check("bp/valid", b1.out_valid, 1);
    hold = b1.cipher_txt;
    check("bp/cipher", hold, vecs[1].exp128);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; plain = ~vecs[1].pt;
      @(negedge clk);
      check($sformatf("bp/hold%0d", i), {b1.cipher_txt, b1.out_valid, b1.in_ready, busy1}, {hold, 3'b101});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp/release", {b1.out_valid, b1.in_ready, busy1}, 3'b010);
    @(negedge clk);
    check("bp/single", {b1.out_valid, b1.in_ready}, 2'b01);

    // Reset at round 12 aborts the block.
    plain = vecs[3].pt; key = vecs[3].key; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (rc1 != 5'd12 && c < 40) begin @(negedge clk); c++; end
    check("rst12/reached", rc1, 12);
    #2 reset = 1'b0;
    #1;
    check("rst12/outs", {b1.out_valid, b1.in_ready, busy1, rc1, b1.cipher_txt}, {3'b010, 5'd0, 64'h0});
    @(negedge clk);
    reset = 1'b1;
    run_block("after_rst", vecs[2].pt, vecs[2].key, vecs[2].exp128, vecs[2].exp80);

    // Reset while a finished block is stalled in DONE.
    out_ready = 1'b0;
    plain = vecs[0].pt; key = vecs[0].key; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (!b1.out_valid && c < 40) begin @(negedge clk); c++; end
    check("rstdone/valid", b1.out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("rstdone/drop", {b1.out_valid, b1.cipher_txt}, {1'b0, 64'h0});
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);

    // Back-to-back: in_valid held high for four blocks, plaintext changed during RUN.
    for (int i = 0; i < 4; i++) begin
      pts[i] = {$urandom, $urandom};
      exp_q.push_back(ref_cipher(pts[i], vecs[1].key, 128));
    end
    key = vecs[1].key; plain = pts[0]; in_valid = 1'b1;
    hs = 0; got = 0; last = -1;
    for (int n = 0; n < 200; n++) begin
      if (got == 4) break;
      if (b1.out_valid) begin
        check($sformatf("b2b/ct%0d", got), b1.cipher_txt, exp_q.pop_front());
        if (got > 0) check($sformatf("b2b/gap%0d", got), cyc - last, 27);
        last = cyc;
        got++;
      end
      if (in_valid && b1.in_ready) hs++;
      @(negedge clk);
      if (hs < 4) plain = pts[hs];
      else begin in_valid = 1'b0; plain = ~plain; end
    end
    check("b2b/count", got, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
